hs_ram_arbiter: RTL and testbench

// - Shares the game work-RAM port between the game CPU and the hiscore save/restore engine.
// - CPU owns the port by default. On a hiscore request, the block asks the pause system to halt the CPU, waits for pause and a settle period, then grants the port.
// - The hiscore engine then runs req/ack accesses until it goes quiet; the block then hands the port back and releases the pause.

---
 rtl/hs_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares game work-RAM between the CPU and the hiscore engine via a pause/settle/grant handshake.
// Optional HS_ARB_TIMEOUT_EN adds a PAUSE_WAIT timeout with a sticky timeout_err flag.
module hs_ram_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int HOLD_CYC    = 16,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_we,
  input  logic [DW-1:0] hs_wdata,
  output logic          hs_ack,
  output logic [DW-1:0] hs_rdata,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          hs_owner,
  output logic          timeout_err
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC + 1) : 1;
  localparam int RW = 2;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC > 1 ? SETTLE_CYC - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC > 1 ? HOLD_CYC - 1 : 0);
  localparam logic [RW-1:0] RD_LD     = RW'(RD_LAT > 1 ? RD_LAT - 1 : 0);

  if (RD_LAT < 1 || RD_LAT > 3 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("hs_ram_arbiter: RD_LAT must be 1..3 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {IDLE, PAUSE_WAIT, SETTLE, OWN, ACCESS, RDWAIT, ACK, RELEASE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rd_cnt, rd_n;
  logic          pause_n, owner_n, we_n, acc_we;
  logic [DW-1:0] rdata_n, wdata_n, acc_wdata;
  logic [AW-1:0] addr_n, acc_addr;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC > 1 ? TIMEOUT_CYC - 1 : 0);
  logic [TW-1:0] to_cnt, to_n;
  logic          req_block, block_n, err_n;
`else
  logic req_block;
  assign req_block   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    hold_n   = '0;
    rd_n     = rd_cnt;
    pause_n  = pause_req;
    owner_n  = hs_owner;
    rdata_n  = hs_rdata;
    addr_n   = acc_addr;
    we_n     = acc_we;
    wdata_n  = acc_wdata;
`ifdef HS_ARB_TIMEOUT_EN
    to_n     = '0;
    block_n  = req_block && hs_req;
    err_n    = timeout_err;
`endif
    case (state)
      // a still-high paused here is the stale ack of the previous grant
      IDLE:
        if (hs_req && !paused && !req_block) begin
          state_n = PAUSE_WAIT;
          pause_n = 1'b1;
        end
      PAUSE_WAIT:
        if (paused) begin
          state_n  = SETTLE;
          settle_n = SETTLE_LD;
        end
`ifdef HS_ARB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_n = IDLE;
          pause_n = 1'b0;
          err_n   = 1'b1;
          block_n = 1'b1;
        end else
          to_n = to_cnt + 1'b1;
`endif
      SETTLE:
        if (settle_cnt <= SW'(1)) begin
          state_n = OWN;
          owner_n = 1'b1;
        end else
          settle_n = settle_cnt - 1'b1;
      OWN:
        if (hs_req) begin
          state_n = ACCESS;
          addr_n  = hs_addr;
          we_n    = hs_we;
          wdata_n = hs_wdata;
        end else if (hold_cnt == HOLD_LAST)
          state_n = RELEASE;
        else
          hold_n = hold_cnt + 1'b1;
      ACCESS: begin
        state_n = acc_we ? ACK : RDWAIT;
        rd_n    = RD_LD;
      end
      RDWAIT:
        if (rd_cnt == '0) begin
          state_n = ACK;
          rdata_n = ram_rdata;
        end else
          rd_n = rd_cnt - 1'b1;
      ACK: state_n = OWN;
      RELEASE: begin
        state_n = IDLE;
        owner_n = 1'b0;
        pause_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      rd_cnt     <= '0;
      pause_req  <= 1'b0;
      hs_owner   <= 1'b0;
      hs_rdata   <= '0;
      acc_addr   <= '0;
      acc_we     <= 1'b0;
      acc_wdata  <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      hold_cnt   <= hold_n;
      rd_cnt     <= rd_n;
      pause_req  <= pause_n;
      hs_owner   <= owner_n;
      hs_rdata   <= rdata_n;
      acc_addr   <= addr_n;
      acc_we     <= we_n;
      acc_wdata  <= wdata_n;
    end

`ifdef HS_ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      to_cnt      <= '0;
      req_block   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_n;
      req_block   <= block_n;
      timeout_err <= err_n;
    end
`endif

  assign hs_ack    = state == ACK;
  assign cpu_rdata = ram_rdata;
  assign ram_addr  = hs_owner ? acc_addr : cpu_addr;
  assign ram_wdata = hs_owner ? acc_wdata : cpu_wdata;
  assign ram_we    = hs_owner ? (state == ACCESS && acc_we) : cpu_we;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: randomized self-checking bench for hs_ram_arbiter with a behavioural RAM and write-history model.
module tb_hs_ram_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0, hs_addr = '0, ram_addr;
  logic [7:0]  cpu_wdata = '0, hs_wdata = '0, cpu_rdata, hs_rdata, ram_wdata, ram_rdata;
  logic        cpu_we = 1'b0, hs_req = 1'b0, hs_we = 1'b0, paused = 1'b0;
  logic        hs_ack, pause_req, ram_we, hs_owner, timeout_err;
  int          checks = 0, failures = 0;
  logic [15:0] addrs [8];

  always #5 clk_sys = ~clk_sys;

  hs_ram_arbiter #(.TIMEOUT_CYC(100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .hs_req(hs_req), .hs_addr(hs_addr),
    .hs_we(hs_we), .hs_wdata(hs_wdata), .hs_ack(hs_ack), .hs_rdata(hs_rdata),
    .pause_req(pause_req), .paused(paused), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .hs_owner(hs_owner), .timeout_err(timeout_err)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] * 8'd7 + 8'd3 ^ a[15:8];
  endfunction

  // RAM with one cycle of read latency; unwritten cells return a fixed pattern
  logic [7:0] mem [65536];
  bit         wr_f [65536];
  logic [7:0] rd_q;
  always @(posedge clk_sys) begin
    rd_q <= wr_f[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    if (ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      wr_f[ram_addr] <= 1'b1;
    end
  end
  assign ram_rdata = rd_q;

  // expected memory contents: the last value the bench meant to write at each address
  logic [7:0] exp_wr [int];
  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return exp_wr.exists(int'(a)) ? exp_wr[int'(a)] : init_val(a);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({pause_req, hs_ack, hs_owner, timeout_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got={pause,ack,owner,err}=%b exp=0000", {pause_req, hs_ack, hs_owner, timeout_err});
    end
    checks++;
    if (hs_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", hs_rdata); end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_cpu_only();
    cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    #1;
    checks++;
    if ({ram_addr, ram_we, ram_wdata} !== {16'h1234, 1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL cpu_mux got addr=%h we=%b wd=%h exp 1234/1/5a", ram_addr, ram_we, ram_wdata);
    end
    exp_wr[16'h1234] = 8'h5A;
    @(negedge clk_sys);
    cpu_addr = 16'h0040; cpu_wdata = 8'hC3;
    #1;
    checks++;
    if ({ram_addr, ram_we, ram_wdata} !== {16'h0040, 1'b1, 8'hC3}) begin
      failures++;
      $display("FAIL cpu_mux2 got addr=%h we=%b wd=%h exp 0040/1/c3", ram_addr, ram_we, ram_wdata);
    end
    exp_wr[16'h0040] = 8'hC3;
    @(negedge clk_sys);
    cpu_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] a;
      a = i == 0 ? 16'h1234 : 16'($urandom);
      cpu_addr = a;
      @(negedge clk_sys);
      checks++;
      if (cpu_rdata !== exp_rd(a) || ram_addr !== a || ram_we !== 1'b0 || pause_req !== 1'b0) begin
        failures++;
        $display("FAIL cpu_read a=%h got rd=%h addr=%h we=%b pause=%b exp rd=%h pause=0", a, cpu_rdata, ram_addr, ram_we, pause_req, exp_rd(a));
      end
    end
  endtask

  // raise hs_req for a read of 0x0040, answer pause after 3 cycles, expect grant then the read
  task automatic test_grant_read();
    hs_addr = 16'h0040; hs_we = 1'b0; hs_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_sys);
      checks++;
      if (pause_req !== 1'b1 || hs_owner !== 1'b0) begin
        failures++;
        $display("FAIL pause_rise k=%0d got pause=%b owner=%b exp 1/0", k, pause_req, hs_owner);
      end
    end
    paused = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_sys);
      checks++;
      if (hs_owner !== (k == 4)) begin
        failures++;
        $display("FAIL grant_time k=%0d got owner=%b exp=%b", k, hs_owner, k == 4);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_sys);
      checks++;
      if (hs_ack !== (k == 3)) begin failures++; $display("FAIL read_ack k=%0d got=%b exp=%b", k, hs_ack, k == 3); end
    end
    checks++;
    if (hs_rdata !== 8'hC3) begin failures++; $display("FAIL read_data got=%h exp=c3", hs_rdata); end
    hs_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (hs_ack !== 1'b0) begin failures++; $display("FAIL ack_pulse got=%b exp=0", hs_ack); end
  endtask

  // one access: drive now, expect ack exactly lat negedges later; write path checked on the RAM port
  task automatic hs_xfer(input logic we, input logic [15:0] a, input logic [7:0] d, input int lat, output int acked);
    hs_addr = a; hs_we = we; hs_wdata = d; hs_req = 1'b1;
    acked = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_sys);
      checks++;
      if (hs_ack !== (k == lat)) begin
        failures++;
        $display("FAIL xfer_ack a=%h we=%b k=%0d got=%b exp=%b", a, we, k, hs_ack, k == lat);
      end else if (k == lat) acked = 1;
      if (we && k == lat - 1) begin
        checks++;
        if ({ram_addr, ram_we, ram_wdata} !== {a, 1'b1, d}) begin
          failures++;
          $display("FAIL xfer_ram got addr=%h we=%b wd=%h exp %h/1/%h", ram_addr, ram_we, ram_wdata, a, d);
        end
      end
    end
    if (we) exp_wr[int'(a)] = d;
  endtask

  task automatic test_burst_release();
    int lat, acks, ok, gap;
    lat = 2; acks = 0;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 16'($urandom);
      hs_xfer(1'b1, addrs[i], 8'($urandom), lat, ok);
      acks += ok;
      lat = 3;
      if (i == 3) begin
        hs_req = 1'b0;
        gap = $urandom_range(1, 12);
        repeat (gap) begin
          @(negedge clk_sys);
          checks++;
          if (hs_owner !== 1'b1 || hs_ack !== 1'b0) begin
            failures++;
            $display("FAIL burst_gap got owner=%b ack=%b exp 1/0", hs_owner, hs_ack);
          end
        end
        lat = 2;
      end
    end
    checks++;
    if (acks != 8) begin failures++; $display("FAIL burst_acks got=%0d exp=8", acks); end
    hs_req = 1'b0;
    cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hFF;
    // 16 idle cycles, one release cycle, then the port is back with the CPU
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_sys);
      checks++;
      if (hs_owner !== (k < 18) || pause_req !== (k < 18) || ram_we !== (k == 18)) begin
        failures++;
        $display("FAIL release k=%0d got owner=%b pause=%b ram_we=%b exp %b/%b/%b", k, hs_owner, pause_req, ram_we, k < 18, k < 18, k == 18);
      end
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_stale_pause_readback();
    int lat, ok;
    hs_addr = addrs[0]; hs_we = 1'b0; hs_req = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      checks++;
      if (pause_req !== 1'b0) begin failures++; $display("FAIL stale_pause got=%b exp=0", pause_req); end
    end
    paused = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (pause_req !== 1'b1) begin failures++; $display("FAIL stale_regrant got=%b exp=1", pause_req); end
    paused = 1'b1;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (hs_owner !== 1'b1) begin failures++; $display("FAIL stale_owner got=%b exp=1", hs_owner); end
    lat = 3;
    for (int i = 0; i < 8; i++) begin
      hs_xfer(1'b0, addrs[i], 8'h00, lat, ok);
      checks++;
      if (hs_rdata !== exp_rd(addrs[i])) begin
        failures++;
        $display("FAIL readback a=%h got=%h exp=%h", addrs[i], hs_rdata, exp_rd(addrs[i]));
      end
      lat = 4;
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_addr = 16'h2222; cpu_we = 1'b0;
    hs_addr = 16'hBEEF; hs_we = 1'b0; hs_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (ram_addr !== 16'hBEEF || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL own_mux got addr=%h we=%b exp beef/0", ram_addr, ram_we);
    end
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({pause_req, hs_ack, hs_owner, timeout_err} !== 4'b0000 || hs_rdata !== 8'h00 || ram_addr !== 16'h2222 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ctl=%b rdata=%h addr=%h we=%b exp 0000/00/2222/0", {pause_req, hs_ack, hs_owner, timeout_err}, hs_rdata, ram_addr, ram_we);
    end
    hs_req = 1'b0; paused = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

`ifdef HS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    hs_req = 1'b1; paused = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (pause_req !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", pause_req); end
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_sys);
      if (i >= 99) begin
        checks++;
        if (pause_req !== (i < 100) || timeout_err !== (i == 100)) begin
          failures++;
          $display("FAIL to_expire i=%0d got pause=%b err=%b exp %b/%b", i, pause_req, timeout_err, i < 100, i == 100);
        end
      end
    end
    repeat (5) begin
      @(negedge clk_sys);
      checks++;
      if (pause_req !== 1'b0) begin failures++; $display("FAIL to_block got=%b exp=0", pause_req); end
    end
    hs_req = 1'b0;
    @(negedge clk_sys);
    hs_req = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (pause_req !== 1'b1 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_rearm got pause=%b err=%b exp 1/1", pause_req, timeout_err);
    end
    hs_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_only();
    test_grant_read();
    test_burst_release();
    test_stale_pause_readback();
    test_reset_mid_read();
`ifdef HS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
